// File: rtl/frame_tx_arbiter_pkg.sv
// Shared types and constants for the frame transmitter arbiter.
//   payload_t        : frame payload handed from a source to the transmitter
//   state_t          : arbiter FSM states
//   PAYLOAD_TYPE_*   : payload type codes used at the top-level hookup
//   REQ_IDX_*        : fixed requester slot assignments
package frame_tx_arbiter_pkg;

  localparam int unsigned PAYLOAD_DATA_W = 24;

  typedef struct packed {
    logic [7:0]                payload_type;
    logic [PAYLOAD_DATA_W-1:0] data;
  } payload_t;

  localparam logic [7:0]  PAYLOAD_TYPE_PULSE_ID = 8'h01;
  localparam int unsigned REQ_IDX_PULSE_ID      = 0;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/frame_tx_arbiter_rr_picker.sv
// Combinational round-robin search: first set bit of req at or after start,
// wrapping from N_BITS-1 back to 0.
//   req     : request bits
//   start   : search start position (must be < N_BITS)
//   valid_c : any request bit set
//   idx_c   : position of the selected bit (0 when none)
module rr_picker #(
  parameter int unsigned N_BITS = 3,
  parameter int unsigned IDX_W  = 2
) (
  input  logic [N_BITS-1:0] req,
  input  logic [IDX_W-1:0]  start,
  output logic              valid_c,
  output logic [IDX_W-1:0]  idx_c
);

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    int p;
    valid_c = 1'b0;
    idx_c   = '0;
    p       = 0;
    for (int o = int'(N_BITS) - 1; o >= 0; o--) begin
      p = int'(start) + o;
      if (p >= int'(N_BITS)) p = p - int'(N_BITS);
      if (req[p]) begin
        valid_c = 1'b1;
        idx_c   = IDX_W'(p);
      end
    end
  end

endmodule

// File: rtl/frame_tx_arbiter.sv
// Shares one frame transmitter between N_REQ payload sources.
// Index 0 (pulse-ID) has priority, limited by a starvation guard; indices
// 1..N_REQ-1 are served round-robin. One frame in flight at a time.
//   clk_i, reset_ni : clock, async active-low reset
//   req_i/payload_i : per-source request and payload (held until ack)
//   ack_o           : one-cycle accept pulse per source
//   tx_ready_i      : transmitter idle (sampled in IDLE only)
//   tx_start_o      : one-cycle start pulse, tx_payload_o valid with it
//   tx_done_i       : frame complete pulse (honoured in WAIT_DONE only)
//   grant_idx_o     : current/last granted source
//   busy_o          : arbiter not idle
//   timeout_o       : one-cycle pulse when tx_done_i never arrived
//   frames_sent_o   : completed frame count, wraps
module frame_tx_arbiter
  import frame_tx_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic [N_REQ-1:0]           req_i,
  input  payload_t [N_REQ-1:0]       payload_i,
  output logic [N_REQ-1:0]           ack_o,
  input  logic                       tx_ready_i,
  output logic                       tx_start_o,
  output payload_t                   tx_payload_o,
  input  logic                       tx_done_i,
  output logic [$clog2(N_REQ)-1:0]   grant_idx_o,
  output logic                       busy_o,
  output logic                       timeout_o,
  output logic [15:0]                frames_sent_o
);

  localparam int unsigned IDX_W   = $clog2(N_REQ);
  localparam int unsigned SC_W    = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned TO_W    = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned RR_BITS = N_REQ - 1;

  state_t            state;
  logic [IDX_W-1:0]  rr_ptr;      // next round-robin index to consider (1..N_REQ-1)
  logic [SC_W-1:0]   starve_cnt;  // consecutive index-0 grants with others waiting
  logic [TO_W-1:0]   to_cnt;

  logic              others_c;
  logic              pick0_c;
  logic              rr_valid_c;
  logic [IDX_W-1:0]  rr_idx_c;
  logic [IDX_W-1:0]  win_c;
  logic [IDX_W-1:0]  next_ptr_c;

  assign others_c = |req_i[N_REQ-1:1];

  // Round-robin over indices 1..N_REQ-1, mapped to picker bits 0..N_REQ-2.
  rr_picker #(
    .N_BITS (RR_BITS),
    .IDX_W  (IDX_W)
  ) u_rr_picker (
    .req     (req_i[N_REQ-1:1]),
    .start   (rr_ptr - IDX_W'(1)),
    .valid_c (rr_valid_c),
    .idx_c   (rr_idx_c)
  );

  // Pulse-ID wins unless it has starved the others for STARVE_LIMIT frames.
  assign pick0_c = req_i[REQ_IDX_PULSE_ID] &&
                   !((starve_cnt == SC_W'(STARVE_LIMIT)) && others_c);
  assign win_c   = pick0_c ? IDX_W'(REQ_IDX_PULSE_ID) : rr_idx_c + IDX_W'(1);

  // Pointer just past the last grant, wrapping N_REQ back to 1.
  assign next_ptr_c = (grant_idx_o == IDX_W'(N_REQ - 1)) ? IDX_W'(1)
                                                         : grant_idx_o + IDX_W'(1);

  // Arbiter FSM with registered outputs.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state         <= ST_IDLE;
      rr_ptr        <= IDX_W'(1);
      starve_cnt    <= '0;
      to_cnt        <= '0;
      ack_o         <= '0;
      tx_start_o    <= 1'b0;
      tx_payload_o  <= '0;
      grant_idx_o   <= '0;
      busy_o        <= 1'b0;
      timeout_o     <= 1'b0;
      frames_sent_o <= '0;
    end else begin
      ack_o      <= '0;
      tx_start_o <= 1'b0;
      timeout_o  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (tx_ready_i && (pick0_c || rr_valid_c)) begin
            tx_payload_o <= payload_i[win_c];
            grant_idx_o  <= win_c;
            ack_o        <= N_REQ'(1) << win_c;
            tx_start_o   <= 1'b1;
            busy_o       <= 1'b1;
            state        <= ST_SEND;
          end
        end
        ST_SEND: begin
          to_cnt <= '0;
          state  <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (tx_done_i) begin
            frames_sent_o <= frames_sent_o + 16'd1;
            if (grant_idx_o != IDX_W'(REQ_IDX_PULSE_ID)) begin
              rr_ptr     <= next_ptr_c;
              starve_cnt <= '0;
            end else if (others_c) begin
              if (starve_cnt != SC_W'(STARVE_LIMIT)) starve_cnt <= starve_cnt + SC_W'(1);
            end else begin
              starve_cnt <= '0;
            end
            busy_o <= 1'b0;
            state  <= ST_IDLE;
          end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            // Abort; still move the pointer so a stuck source cannot hog the link.
            timeout_o <= 1'b1;
            if (grant_idx_o != IDX_W'(REQ_IDX_PULSE_ID)) rr_ptr <= next_ptr_c;
            busy_o <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        default: begin
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_tx_arbiter.sv
// Self-checking bench for frame_tx_arbiter: directed scenarios plus a
// randomized phase, checked against a rule-level arbitration model.
`timescale 1ns/1ps
module tb_frame_tx_arbiter;
  import frame_tx_arbiter_pkg::*;

  localparam int N_REQ          = 4;
  localparam int STARVE_LIMIT   = 4;
  localparam int TIMEOUT_CYCLES = 40;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic [N_REQ-1:0]     req = '0;
  payload_t [N_REQ-1:0] payload = '0;
  logic [N_REQ-1:0]     ack;
  logic                 tx_ready = 1'b0;
  logic                 tx_start;
  payload_t             tx_payload;
  logic                 tx_done = 1'b0;
  logic [1:0]           grant_idx;
  logic                 busy;
  logic                 timeout;
  logic [15:0]          frames_sent;

  frame_tx_arbiter #(
    .N_REQ          (N_REQ),
    .STARVE_LIMIT   (STARVE_LIMIT),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk_i         (clk),
    .reset_ni      (reset_n),
    .req_i         (req),
    .payload_i     (payload),
    .ack_o         (ack),
    .tx_ready_i    (tx_ready),
    .tx_start_o    (tx_start),
    .tx_payload_o  (tx_payload),
    .tx_done_i     (tx_done),
    .grant_idx_o   (grant_idx),
    .busy_o        (busy),
    .timeout_o     (timeout),
    .frames_sent_o (frames_sent)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: last served round-robin source (0 = none yet),
  // consecutive pulse-ID grants with others waiting, completed frames.
  int       last_rr = 0;
  int       zero_streak = 0;
  int       exp_frames = 0;
  payload_t exp_payload = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_winner(input logic [3:0] r);
    int start;
    int i;
    if (r[0] && !(zero_streak >= STARVE_LIMIT && (r[3:1] != 3'b000))) return 0;
    start = (last_rr % (N_REQ - 1)) + 1;
    for (int k = 0; k < N_REQ - 1; k++) begin
      i = ((start - 1 + k) % (N_REQ - 1)) + 1;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  // One arbitrated frame: request, accept, then completion or timeout.
  task automatic run_frame(input logic [3:0] reqs, input int ready_delay, input int done_delay,
                           input bit timeout_case, input bit send_done, output int w);
    int lat;
    int k;
    for (int i = 0; i < N_REQ; i++) payload[i] = payload_t'($urandom());
    w = model_winner(reqs);
    tx_ready = (ready_delay == 0);
    req = reqs;
    for (int c = 0; c < ready_delay; c++) begin
      @(negedge clk);
      check("gated_no_ack", 32'(ack), 32'd0);
    end
    tx_ready = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (ack == '0 && lat < 8);
    check("ack_latency", 32'(lat), 32'd1);
    check("ack_onehot", 32'(ack), 32'(1) << w);
    check("tx_start", 32'(tx_start), 32'd1);
    check("grant_idx", 32'(grant_idx), 32'(w));
    exp_payload = payload[w];
    check("tx_payload", tx_payload, exp_payload);
    check("busy_send", 32'(busy), 32'd1);
    req = reqs & ~(4'(1) << w);
    if (send_done) tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    check("ack_cleared", 32'(ack), 32'd0);
    check("start_cleared", 32'(tx_start), 32'd0);
    check("busy_wait", 32'(busy), 32'd1);
    if (!timeout_case) begin
      repeat (done_delay) @(negedge clk);
      check("busy_before_done", 32'(busy), 32'd1);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      exp_frames = (exp_frames + 1) % 65536;
      if (w != 0) begin
        last_rr = w;
        zero_streak = 0;
      end else if (req[3:1] != 3'b000) begin
        if (zero_streak < STARVE_LIMIT) zero_streak++;
      end else begin
        zero_streak = 0;
      end
      check("busy_after_done", 32'(busy), 32'd0);
      check("frames_sent", 32'(frames_sent), 32'(exp_frames));
      check("payload_held", tx_payload, exp_payload);
      check("no_timeout", 32'(timeout), 32'd0);
      req = '0;
    end else begin
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!timeout && k < TIMEOUT_CYCLES + 5);
      check("timeout_latency", 32'(k), 32'(TIMEOUT_CYCLES));
      check("timeout_frames", 32'(frames_sent), 32'(exp_frames));
      check("timeout_busy", 32'(busy), 32'd0);
      if (w != 0) last_rr = w;
      req = '0;
      @(negedge clk);
      check("timeout_pulse_width", 32'(timeout), 32'd0);
    end
  endtask

  int g;
  int starve_exp [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

  initial begin
    // Reset values
    @(negedge clk);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_start", 32'(tx_start), 32'd0);
    check("rst_payload", tx_payload, 32'd0);
    check("rst_grant", 32'(grant_idx), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_frames", 32'(frames_sent), 32'd0);
    reset_n = 1'b1;

    // Single request from source 2
    run_frame(4'b0100, 0, 2, 1'b0, 1'b0, g);
    check("single_grant", 32'(g), 32'd2);

    // Round-robin among 1..3; continues after source 2
    for (int n = 0; n < 6; n++) begin
      run_frame(4'b1110, 0, $urandom_range(0, 3), 1'b0, 1'b0, g);
      check("rr_order", 32'(g), 32'(((n + 2) % 3) + 1));
    end

    // Pulse-ID priority with starvation guard
    for (int n = 0; n < 10; n++) begin
      run_frame(4'b0011, 0, 1, 1'b0, 1'b0, g);
      check("starve_order", 32'(g), 32'(starve_exp[n]));
    end

    // Timeout on source 2, then the pointer has moved on to 3
    run_frame(4'b1110, 0, 0, 1'b1, 1'b0, g);
    check("timeout_grant", 32'(g), 32'd2);
    run_frame(4'b1110, 0, 1, 1'b0, 1'b0, g);
    check("after_timeout_grant", 32'(g), 32'd3);

    // Ready gating; done pulsed during SEND must be ignored
    run_frame(4'b0001, 50, 1, 1'b0, 1'b1, g);

    // Stray done while idle
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    @(negedge clk);
    check("stray_done_frames", 32'(frames_sent), 32'(exp_frames));
    check("stray_done_busy", 32'(busy), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 30; n++) begin
      run_frame(4'($urandom_range(1, 15)), ($urandom_range(0, 7) == 0) ? 3 : 0,
                $urandom_range(0, 4), ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)), g);
    end

    // Reset mid-frame: pointer left at 2, then reset sends it back to 1
    run_frame(4'b0010, 0, 0, 1'b0, 1'b0, g);
    req = 4'b0010;
    @(negedge clk);
    check("pre_reset_ack", 32'(ack), 32'b0010);
    req = '0;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_ack", 32'(ack), 32'd0);
    check("mid_rst_start", 32'(tx_start), 32'd0);
    check("mid_rst_payload", tx_payload, 32'd0);
    check("mid_rst_grant", 32'(grant_idx), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_timeout", 32'(timeout), 32'd0);
    check("mid_rst_frames", 32'(frames_sent), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    last_rr = 0;
    zero_streak = 0;
    exp_frames = 0;
    run_frame(4'b1010, 0, 1, 1'b0, 1'b0, g);
    check("post_rst_grant", 32'(g), 32'd1);
    run_frame(4'b1000, 0, 1, 1'b0, 1'b0, g);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
